// File: rtl/plot_port_arbiter.sv
// Round-robin owner of the framebuffer write port: grants one client a solid
// box fill, plots it row-major at one pixel per clock, then pulses done.
module plot_port_arbiter #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int COL_W = 3,
  parameter int BOX_W = 4,
  parameter int BOX_H = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [X_W-1:0]   x0,
  input  logic [X_W-1:0]   x1,
  input  logic [Y_W-1:0]   y0,
  input  logic [Y_W-1:0]   y1,
  input  logic [COL_W-1:0] col0,
  input  logic [COL_W-1:0] col1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot,
  output logic [1:0]       fsm_state
);

  localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: req is a level sampled only in IDLE; the granted client sees
  // gnt for the whole burst and done for exactly one cycle at its end.
  state_t         state;
  logic           owner;
  logic           last_served;
  logic [X_W-1:0] ox;
  logic [Y_W-1:0] oy;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;

  logic             winner;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [COL_W-1:0] sel_col;
  logic             dx_last;
  logic             dy_last;
  logic [DXW-1:0]   dx_nxt;
  logic [DYW-1:0]   dy_nxt;

  assign fsm_state = state;

  always_comb begin
    winner  = (req == 2'b11) ? ~last_served : req[1];
    sel_x   = winner ? x1 : x0;
    sel_y   = winner ? y1 : y0;
    sel_col = winner ? col1 : col0;
    dx_last = (dx == DXW'(BOX_W - 1));
    dy_last = (dy == DYW'(BOX_H - 1));
    dx_nxt  = dx_last ? '0 : dx + DXW'(1);
    dy_nxt  = dx_last ? dy + DYW'(1) : dy;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      ox          <= '0;
      oy          <= '0;
      dx          <= '0;
      dy          <= '0;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            // First pixel is the origin itself, so it goes out with the grant.
            owner      <= winner;
            ox         <= sel_x;
            oy         <= sel_y;
            gnt        <= winner ? 2'b10 : 2'b01;
            busy       <= 1'b1;
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_col;
            vga_plot   <= 1'b1;
            dx         <= '0;
            dy         <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (dx_last && dy_last) begin
            vga_plot <= 1'b0;
            done     <= owner ? 2'b10 : 2'b01;
            state    <= DONE;
          end else begin
            dx    <= dx_nxt;
            dy    <= dy_nxt;
            vga_x <= ox + X_W'(dx_nxt);
            vga_y <= oy + Y_W'(dy_nxt);
          end
        end
        DONE: begin
          done        <= '0;
          gnt         <= '0;
          busy        <= 1'b0;
          last_served <= owner;
          dx          <= '0;
          dy          <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Bench for plot_port_arbiter: a per-burst expectation queue model checked
// every cycle, plus directed scenarios with literal pixel/grant expectations.
module tb_plot_port_arbiter;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int BOX_W = 4;
  localparam int BOX_H = 4;
  localparam int EW    = 1 + 1 + 2 + 2 + 1 + X_W + Y_W + COL_W;
  localparam int PW    = X_W + Y_W + COL_W;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]       req;
  logic [X_W-1:0]   x0, x1;
  logic [Y_W-1:0]   y0, y1;
  logic [COL_W-1:0] col0, col1;
  logic [1:0]       gnt, done;
  logic             busy;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [COL_W-1:0] vga_colour;
  logic             vga_plot;
  logic [1:0]       fsm_state;

  plot_port_arbiter #(
    .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .BOX_W(BOX_W), .BOX_H(BOX_H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .col0(col0), .col1(col1),
    .gnt(gnt), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: one entry per expected output cycle of a burst
  logic [EW-1:0] exp_q[$];
  logic             m_last;
  logic             e_win, e_plot, e_busy;
  logic [1:0]       e_done, e_gnt;
  logic [X_W-1:0]   e_x;
  logic [Y_W-1:0]   e_y;
  logic [COL_W-1:0] e_col;

  initial begin
    logic             s_rst, win;
    logic [1:0]       s_req;
    logic [X_W-1:0]   ox, lx;
    logic [Y_W-1:0]   oy, ly;
    logic [COL_W-1:0] ocol;
    logic [1:0]       g;
    forever begin
      @(posedge clk);
      s_rst = reset_n;
      s_req = req;
      if (!s_rst) begin
        exp_q.delete();
        m_last = 1'b1;
        {e_win, e_plot, e_done, e_gnt, e_busy, e_x, e_y, e_col} = '0;
      end else begin
        if (exp_q.size() == 0 && s_req != 2'b00) begin
          win  = (s_req == 2'b11) ? ~m_last : s_req[1];
          ox   = win ? x1 : x0;
          oy   = win ? y1 : y0;
          ocol = win ? col1 : col0;
          g    = win ? 2'b10 : 2'b01;
          lx   = ox;
          ly   = oy;
          for (int r = 0; r < BOX_H; r++) begin
            for (int c = 0; c < BOX_W; c++) begin
              lx = X_W'((int'(ox) + c) % (1 << X_W));
              ly = Y_W'((int'(oy) + r) % (1 << Y_W));
              exp_q.push_back({win, 1'b1, 2'b00, g, 1'b1, lx, ly, ocol});
            end
          end
          exp_q.push_back({win, 1'b0, g, g, 1'b1, lx, ly, ocol});
          exp_q.push_back({win, 1'b0, 2'b00, 2'b00, 1'b0, lx, ly, ocol});
        end
        if (exp_q.size() != 0) begin
          {e_win, e_plot, e_done, e_gnt, e_busy, e_x, e_y, e_col} = exp_q.pop_front();
          if (e_done != 2'b00) m_last = e_win;
        end else begin
          e_plot = 1'b0;
          e_done = 2'b00;
          e_gnt  = 2'b00;
          e_busy = 1'b0;
        end
      end
      @(negedge clk);
      check("gnt", gnt, e_gnt);
      check("done", done, e_done);
      check("busy", busy, e_busy);
      check("plot", vga_plot, e_plot);
      check("vga_x", vga_x, e_x);
      check("vga_y", vga_y, e_y);
      check("colour", vga_colour, e_col);
    end
  end

  // monitor: plotted pixels, grant rises, done pulses
  logic [PW-1:0] px_q[$];
  logic [1:0]    gnt_q[$];
  int            done_cnt = 0;
  initial begin
    logic [1:0] prev_gnt;
    prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      if (vga_plot === 1'b1) px_q.push_back({vga_x, vga_y, vga_colour});
      if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_q.push_back(gnt);
      if (done != 2'b00) done_cnt++;
      prev_gnt = gnt;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 2'b00;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    px_q.delete();
    gnt_q.delete();
  endtask

  task automatic wait_done(input int c, input string name);
    int k;
    k = 0;
    while (done[c] !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done pulse, expected done[%0d] within 100 cycles", name, c);
    end
  endtask

  task automatic wait_px(input int n, input string name);
    int k;
    k = 0;
    while (px_q.size() < n && k < 100) begin
      tick(1);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d plots, expected %0d within 100 cycles", name, px_q.size(), n);
    end
  endtask

  initial begin
    int dc;
    reset_n = 1'b0;
    req = 2'b00;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; col0 = '0; col1 = '0;
    tick(3);
    check("rst_gnt", gnt, 2'b00);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_x", vga_x, 0);
    do_reset();

    // single client box
    x0 = 8'd10; y0 = 7'd20; col0 = 3'b100; req = 2'b01;
    tick(1);
    check("t1_lat_gnt", gnt, 2'b01);
    check("t1_lat_plot", vga_plot, 1'b1);
    wait_done(0, "t1_done");
    req = 2'b00;
    check("t1_count", px_q.size(), 16);
    check("t1_p0", px_q[0], {8'd10, 7'd20, 3'b100});
    check("t1_p5", px_q[5], {8'd11, 7'd21, 3'b100});
    check("t1_p15", px_q[15], {8'd13, 7'd23, 3'b100});
    tick(3);

    // both request after reset
    do_reset();
    x0 = 8'd0; y0 = 7'd0; col0 = 3'b001;
    x1 = 8'd50; y1 = 7'd60; col1 = 3'b010;
    req = 2'b11;
    wait_done(0, "t2_done0");
    req = 2'b10;
    wait_done(1, "t2_done1");
    req = 2'b00;
    check("t2_count", px_q.size(), 32);
    check("t2_c0_first", px_q[0], {8'd0, 7'd0, 3'b001});
    check("t2_c1_first", px_q[16], {8'd50, 7'd60, 3'b010});
    check("t2_c1_last", px_q[31], {8'd53, 7'd63, 3'b010});
    tick(3);

    // both held for four bursts
    do_reset();
    req = 2'b11;
    wait_done(0, "t3_b0"); tick(1);
    wait_done(1, "t3_b1"); tick(1);
    wait_done(0, "t3_b2"); tick(1);
    wait_done(1, "t3_b3");
    req = 2'b00;
    check("t3_g0", gnt_q[0], 2'b01);
    check("t3_g1", gnt_q[1], 2'b10);
    check("t3_g2", gnt_q[2], 2'b01);
    check("t3_g3", gnt_q[3], 2'b10);
    tick(3);

    // coordinate wrap
    do_reset();
    x0 = 8'd254; y0 = 7'd126; col0 = 3'b111; req = 2'b01;
    wait_done(0, "t4_done");
    req = 2'b00;
    check("t4_x1", px_q[1], {8'd255, 7'd126, 3'b111});
    check("t4_x2", px_q[2], {8'd0, 7'd126, 3'b111});
    check("t4_y8", px_q[8], {8'd254, 7'd0, 3'b111});
    check("t4_last", px_q[15], {8'd1, 7'd1, 3'b111});
    tick(3);

    // inputs and req change mid-burst
    do_reset();
    x0 = 8'd30; y0 = 7'd40; col0 = 3'b011; req = 2'b01;
    wait_px(3, "t5_px3");
    x0 = 8'd99; y0 = 7'd5; col0 = 3'b000; req = 2'b00;
    wait_done(0, "t5_done");
    check("t5_count", px_q.size(), 16);
    check("t5_last", px_q[15], {8'd33, 7'd43, 3'b011});
    tick(3);

    // reset mid-burst
    do_reset();
    dc = done_cnt;
    x1 = 8'd70; y1 = 7'd10; col1 = 3'b101; req = 2'b10;
    wait_px(5, "t6_px5");
    reset_n = 1'b0;
    tick(1);
    check("t6_plot", vga_plot, 1'b0);
    check("t6_gnt", gnt, 2'b00);
    reset_n = 1'b1;
    req = 2'b00;
    tick(20);
    check("t6_no_done", done_cnt, dc);
    gnt_q.delete();
    req = 2'b11;
    wait_done(0, "t6_done0");
    check("t6_first_gnt", gnt_q[0], 2'b01);
    req = 2'b10;
    wait_done(1, "t6_done1");
    req = 2'b00;
    tick(3);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        x0 = 8'($urandom); x1 = 8'($urandom);
        y0 = 7'($urandom); y1 = 7'($urandom);
        col0 = 3'($urandom); col1 = 3'($urandom);
      end
      reset_n = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    reset_n = 1'b1;
    req = 2'b00;
    tick(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
